// File: rtl/mux_4_1_arbiter.sv
// Round-robin arbiter sharing one Mux_4_1 datapath among four requesters.
// Optional owner timeout/preemption is enabled by defining ARB_HOLD_TIMEOUT_EN.
module mux_4_1_arbiter #(
  parameter int unsigned MAX_HOLD  = 8,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] request,
  output logic [3:0] grant,
  output logic [1:0] selection,
  output logic       valid,
  output logic       preempt
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e               state_q, state_d;
  logic [3:0]           grant_q, grant_d;
  logic [1:0]           sel_q, sel_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [1:0] owner_next;
  logic [3:0] others;
  logic [1:0] pick_idle;
  logic [1:0] pick_next;

  // First set bit of req, scanning circularly from start.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = start;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  assign owner_next = sel_q + 2'd1;
  assign others     = request & ~grant_q;
  assign pick_idle  = rr_pick(request, ptr_q);
  assign pick_next  = rr_pick(others, owner_next);

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] HoldLast = CNT_WIDTH'(MAX_HOLD - 1);

  logic preempt_q, preempt_d;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
`ifdef ARB_HOLD_TIMEOUT_EN
    preempt_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (|request) begin
          sel_d   = pick_idle;
          grant_d = 4'b0001 << pick_idle;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (!request[sel_q]) begin
          ptr_d = owner_next;
          cnt_d = '0;
          if (|others) begin
            sel_d   = pick_next;
            grant_d = 4'b0001 << pick_next;
          end else begin
            grant_d = 4'b0000;
            state_d = StIdle;
          end
`ifdef ARB_HOLD_TIMEOUT_EN
        end else if ((cnt_q == HoldLast) && (|others)) begin
          // Owner still requesting but has used its slot; hand over to the next waiter.
          ptr_d     = owner_next;
          cnt_d     = '0;
          sel_d     = pick_next;
          grant_d   = 4'b0001 << pick_next;
          preempt_d = 1'b1;
`endif
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= 4'b0000;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ARB_HOLD_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) preempt_q <= 1'b0;
    else     preempt_q <= preempt_d;
  end

  assign preempt = preempt_q;
`else
  assign preempt = 1'b0;
`endif

  assign grant     = grant_q;
  assign selection = sel_q;
  assign valid     = |grant_q;

endmodule

// File: tb/tb_mux_4_1_arbiter.sv
// Directed self-checking bench for mux_4_1_arbiter (MAX_HOLD = 4).
module tb_mux_4_1_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] request;
  logic [3:0] grant;
  logic [1:0] selection;
  logic       valid;
  logic       preempt;

  int checks = 0;
  int errors = 0;

  // {grant, selection, valid, preempt}
  wire [7:0] obs = {grant, selection, valid, preempt};

  mux_4_1_arbiter #(
    .MAX_HOLD (4),
    .CNT_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .request  (request),
    .grant    (grant),
    .selection(selection),
    .valid    (valid),
    .preempt  (preempt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    request = 4'b1111;
    tick();
    tick();
    checks++;
    if (obs !== 8'b0000_00_0_0) begin
      errors++;
      $display("FAIL reset_hold got %b want %b", obs, 8'b0000_00_0_0);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (obs !== 8'b0001_00_1_0) begin
      errors++;
      $display("FAIL reset_release got %b want %b", obs, 8'b0001_00_1_0);
    end
  endtask

  task automatic test_rotation();
    logic [7:0] exp;
    request = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 2; c++) begin
        tick();
        exp = {4'b0001 << k, 2'(k), 1'b1, 1'b0};
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL rotation_hold owner %0d got %b want %b", k, obs, exp);
        end
      end
      request = 4'b1111 & ~(4'b0001 << k);
      tick();
      exp = {4'b0001 << ((k + 1) % 4), 2'((k + 1) % 4), 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rotation_handover from %0d got %b want %b", k, obs, exp);
      end
      request = 4'b1111;
    end
  endtask

  task automatic test_skip_wrap();
    request = 4'b1110;
    tick();
    request = 4'b1101;
    tick();
    checks++;
    if (obs !== 8'b0100_10_1_0) begin
      errors++;
      $display("FAIL skip_reach_owner2 got %b want %b", obs, 8'b0100_10_1_0);
    end
    request = 4'b0011;
    tick();
    checks++;
    if (obs !== 8'b0001_00_1_0) begin
      errors++;
      $display("FAIL skip_wrap got %b want %b", obs, 8'b0001_00_1_0);
    end
    request = 4'b0000;
    tick();
    checks++;
    if (obs !== 8'b0000_00_0_0) begin
      errors++;
      $display("FAIL skip_idle got %b want %b", obs, 8'b0000_00_0_0);
    end
    // ptr is now 1, so idle search reaches requester 2 before 0.
    request = 4'b0101;
    tick();
    checks++;
    if (obs !== 8'b0100_10_1_0) begin
      errors++;
      $display("FAIL idle_ptr_search got %b want %b", obs, 8'b0100_10_1_0);
    end
    request = 4'b0000;
    tick();
  endtask

  task automatic test_idle_return();
    request = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (obs !== 8'b1000_11_1_0) begin
        errors++;
        $display("FAIL idle_single cycle %0d got %b want %b", c, obs, 8'b1000_11_1_0);
      end
    end
    request = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (obs !== 8'b0000_11_0_0) begin
        errors++;
        $display("FAIL idle_return cycle %0d got %b want %b", c, obs, 8'b0000_11_0_0);
      end
    end
    request = 4'b1000;
    tick();
    checks++;
    if (obs !== 8'b1000_11_1_0) begin
      errors++;
      $display("FAIL single_reacquire got %b want %b", obs, 8'b1000_11_1_0);
    end
    request = 4'b0000;
    tick();
  endtask

  task automatic test_mid_reset();
    request = 4'b0010;
    tick();
    checks++;
    if (obs !== 8'b0010_01_1_0) begin
      errors++;
      $display("FAIL midrst_grant got %b want %b", obs, 8'b0010_01_1_0);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (obs !== 8'b0000_00_0_0) begin
      errors++;
      $display("FAIL midrst_clear got %b want %b", obs, 8'b0000_00_0_0);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (obs !== 8'b0010_01_1_0) begin
      errors++;
      $display("FAIL midrst_regrant got %b want %b", obs, 8'b0010_01_1_0);
    end
    request = 4'b0000;
    tick();
  endtask

  task automatic test_hold();
    logic [7:0] exp;
    // ptr is 2 here; search 2,3,0 picks requester 0.
    request = 4'b0011;
`ifdef ARB_HOLD_TIMEOUT_EN
    for (int c = 0; c < 9; c++) begin
      tick();
      if (c == 4) exp = 8'b0010_01_1_1;
      else if (c == 8) exp = 8'b0001_00_1_1;
      else if (c > 4) exp = 8'b0010_01_1_0;
      else exp = 8'b0001_00_1_0;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL timeout cycle %0d got %b want %b", c, obs, exp);
      end
    end
`else
    for (int c = 0; c < 12; c++) begin
      tick();
      exp = 8'b0001_00_1_0;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL no_timeout cycle %0d got %b want %b", c, obs, exp);
      end
    end
`endif
    request = 4'b0000;
    tick();
    request = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (obs !== 8'b0100_10_1_0) begin
        errors++;
        $display("FAIL lone_hold cycle %0d got %b want %b", c, obs, 8'b0100_10_1_0);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    request = 4'b0000;
    test_reset();
    test_rotation();
    test_skip_wrap();
    test_idle_return();
    test_mid_reset();
    test_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
